// File: rtl/gpio_req_arbiter.sv
// Round-robin arbiter sharing one 16-bit GPIO output word between NUM_REQ AXIS requesters.
// Optional readback response path enabled by defining GPIO_ARB_READBACK_EN.

module gpio_req_arbiter_lane (
  input  logic [31:0] tdata,
  input  logic [15:0] shadow,
  output logic [15:0] merged
);
  // [31:16] selects which shadow bits take the new value in [15:0]
  assign merged = (shadow & ~tdata[31:16]) | (tdata[15:0] & tdata[31:16]);
endmodule

module gpio_req_arbiter #(
  parameter  int NUM_REQ     = 4,
  parameter  int HOLD_CYCLES = 16,
  localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_tvalid,
  output logic [NUM_REQ-1:0]    req_tready,
  input  logic [32*NUM_REQ-1:0] req_tdata,
  output logic [31:0]           m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic [31:0]           gpio_rd_in,
  output logic [31:0]           rsp_tdata,
  output logic [ID_W-1:0]       rsp_tid,
  output logic                  rsp_tvalid,
  input  logic                  rsp_tready
);

  localparam int SCAN_W = ID_W + 1;
  localparam int HC_W   = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_DRIVE = 3'd2,
    S_HOLD  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic [ID_W-1:0]           grant_q;
  logic [ID_W-1:0]           rr_ptr_q;
  logic [15:0]               shadow_q;
  logic [HC_W-1:0]           hold_cnt_q;
  logic                      hold_last;
  logic [ID_W-1:0]           win;
  logic                      win_found;
  logic [SCAN_W-1:0]         scan;
  logic [NUM_REQ-1:0][15:0]  lane_merged;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      gpio_req_arbiter_lane u_lane (
        .tdata  (req_tdata[32*gi +: 32]),
        .shadow (shadow_q),
        .merged (lane_merged[gi])
      );
    end
  endgenerate

  // Rotating priority: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    win       = rr_ptr_q;
    win_found = 1'b0;
    scan      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, rr_ptr_q} + SCAN_W'(k);
      if (scan >= SCAN_W'(NUM_REQ)) scan = scan - SCAN_W'(NUM_REQ);
      if (!win_found && req_tvalid[scan[ID_W-1:0]]) begin
        win       = scan[ID_W-1:0];
        win_found = 1'b1;
      end
    end
  end

  assign hold_last = (hold_cnt_q == HC_W'(HOLD_CYCLES - 1));

  always_comb begin
    state_d       = state_q;
    req_tready    = '0;
    m_axis_tvalid = 1'b0;
    case (state_q)
      S_IDLE:  if (win_found) state_d = S_GRANT;
      S_GRANT: begin
        req_tready[grant_q] = 1'b1;
        state_d             = S_DRIVE;
      end
      S_DRIVE: begin
        m_axis_tvalid = 1'b1;
        if (m_axis_tready) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (hold_last) begin
`ifdef GPIO_ARB_READBACK_EN
          state_d = S_RESP;
`else
          state_d = S_IDLE;
`endif
        end
      end
      S_RESP:  if (rsp_tready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      shadow_q   <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && win_found) grant_q <= win;
      if (state_q == S_GRANT) begin
        shadow_q <= lane_merged[grant_q];
        rr_ptr_q <= (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);
      end
      if (state_q == S_HOLD) hold_cnt_q <= hold_last ? '0 : hold_cnt_q + HC_W'(1);
    end
  end

  // Downstream buffer ignores tvalid, so the word is driven continuously.
  assign m_axis_tdata = {16'h0, shadow_q};

`ifdef GPIO_ARB_READBACK_EN
  logic [31:0]     rsp_tdata_q;
  logic [ID_W-1:0] rsp_tid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_tdata_q <= '0;
      rsp_tid_q   <= '0;
    end else if (state_q == S_HOLD && hold_last) begin
      rsp_tdata_q <= gpio_rd_in;
      rsp_tid_q   <= grant_q;
    end
  end

  assign rsp_tvalid = (state_q == S_RESP);
  assign rsp_tdata  = rsp_tdata_q;
  assign rsp_tid    = rsp_tid_q;
`else
  logic unused_readback;
  assign unused_readback = ^{rsp_tready, gpio_rd_in};
  assign rsp_tvalid      = 1'b0;
  assign rsp_tdata       = '0;
  assign rsp_tid         = '0;
`endif

endmodule
